// File: rtl/game_pkg.sv
// Shared types and keycodes for the game/character motion control path.
package game_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    FADE  = 2'd1,
    IDLE  = 2'd2,
    STEP  = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    DOWN  = 2'd0,
    UP    = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_ENTER = 8'h28;

endpackage

// File: rtl/anim_frame_counter.sv
// Walk/run animation sequencer: counts frame ticks per phase and steps 0,1,2,1.
module anim_frame_counter #(
  parameter int unsigned WALK_PHASE = 10,
  parameter int unsigned RUN_PHASE  = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       en,
  input  logic       clr,
  input  logic       run_sel,
  output logic [1:0] frame
);

  localparam int unsigned MAX_PHASE = (WALK_PHASE > RUN_PHASE) ? WALK_PHASE : RUN_PHASE;
  localparam int unsigned CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_n, last;
  logic [1:0]       seq_q, seq_n;

  // >= so a shorter phase selected mid-count still wraps cleanly
  assign last = run_sel ? CNT_W'(RUN_PHASE - 1) : CNT_W'(WALK_PHASE - 1);

  always_comb begin
    cnt_n = cnt_q;
    seq_n = seq_q;
    if (clr) begin
      cnt_n = '0;
      seq_n = '0;
    end else if (en) begin
      if (cnt_q >= last) begin
        cnt_n = '0;
        seq_n = seq_q + 2'd1;
      end else begin
        cnt_n = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
      seq_q <= '0;
    end else begin
      cnt_q <= cnt_n;
      seq_q <= seq_n;
    end
  end

  assign frame = (seq_q == 2'd3) ? 2'd1 : seq_q;

endmodule

// File: rtl/char_motion_fsm.sv
// Game screen FSM plus tile-grid player motion; all state advances on frame_tick.
module char_motion_fsm
  import game_pkg::*;
#(
  parameter int unsigned TILE_PX     = 16,
  parameter int unsigned WALK_PX     = 1,
  parameter int unsigned RUN_PX      = 2,
  parameter int unsigned WALK_PHASE  = 10,
  parameter int unsigned RUN_PHASE   = 5,
  parameter int unsigned FADE_FRAMES = 50,
  parameter int unsigned MAP_W       = 32,
  parameter int unsigned MAP_H       = 32,
  parameter int unsigned START_X     = 4,
  parameter int unsigned START_Y     = 4,
  parameter logic [7:0]  KEY_EXIT    = 8'h1B
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           frame_tick,
  input  logic [7:0]                     keycode,
  input  logic                           run_held,
  output logic [3:0]                     state_num,
  output logic [1:0]                     direction,
  output logic [1:0]                     charMoveFrame,
  output logic                           charIsMoving,
  output logic                           charIsRunning,
  output logic [$clog2(TILE_PX)-1:0]     step_offset,
  output logic [$clog2(MAP_W)-1:0]       tile_x,
  output logic [$clog2(MAP_H)-1:0]       tile_y,
  output logic [$clog2(FADE_FRAMES)-1:0] fade_level,
  output logic                           step_done
);

  localparam int unsigned OFF_W  = $clog2(TILE_PX);
  localparam int unsigned SUM_W  = OFF_W + 1;
  localparam int unsigned X_W    = $clog2(MAP_W);
  localparam int unsigned Y_W    = $clog2(MAP_H);
  localparam int unsigned FADE_W = $clog2(FADE_FRAMES);

  game_state_t       state_q, state_n;
  dir_t              dir_q, dir_n, key_dir;
  logic              key_hit;
  logic [OFF_W-1:0]  off_q, off_n;
  logic [SUM_W-1:0]  off_sum;
  logic [X_W-1:0]    tx_q, tx_n, adv_x;
  logic [Y_W-1:0]    ty_q, ty_n, adv_y;
  logic [FADE_W-1:0] fade_q, fade_n;
  logic              run_q, run_n;
  logic              done_q, done_n;
  logic              anim_en, anim_clr;
  logic [1:0]        anim_frame;

  function automatic logic can_move(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                    input dir_t d);
    case (d)
      DOWN:    can_move = (y != Y_W'(MAP_H - 1));
      UP:      can_move = (y != '0);
      LEFT:    can_move = (x != '0);
      default: can_move = (x != X_W'(MAP_W - 1));
    endcase
  endfunction

  // Direction keys, S > W > A > D
  always_comb begin
    key_hit = 1'b1;
    key_dir = DOWN;
    if (keycode == KEY_S)      key_dir = DOWN;
    else if (keycode == KEY_W) key_dir = UP;
    else if (keycode == KEY_A) key_dir = LEFT;
    else if (keycode == KEY_D) key_dir = RIGHT;
    else                       key_hit = 1'b0;
  end

  // Tile the current step lands on
  always_comb begin
    adv_x = tx_q;
    adv_y = ty_q;
    case (dir_q)
      DOWN:    adv_y = ty_q + Y_W'(1);
      UP:      adv_y = ty_q - Y_W'(1);
      LEFT:    adv_x = tx_q - X_W'(1);
      default: adv_x = tx_q + X_W'(1);
    endcase
  end

  assign off_sum = {1'b0, off_q} + SUM_W'(run_q ? RUN_PX : WALK_PX);

  always_comb begin
    state_n = state_q;
    dir_n   = dir_q;
    off_n   = off_q;
    tx_n    = tx_q;
    ty_n    = ty_q;
    fade_n  = fade_q;
    run_n   = run_q;
    done_n  = 1'b0;
    if (frame_tick) begin
      case (state_q)
        START: begin
          if (keycode == KEY_ENTER) begin
            state_n = FADE;
            fade_n  = '0;
            tx_n    = X_W'(START_X);
            ty_n    = Y_W'(START_Y);
          end
        end
        FADE: begin
          if (fade_q == FADE_W'(FADE_FRAMES - 1)) begin
            fade_n  = '0;
            state_n = IDLE;
          end else begin
            fade_n = fade_q + FADE_W'(1);
          end
        end
        IDLE: begin
          if (keycode == KEY_EXIT) begin
            state_n = START;
          end else if (key_hit) begin
            dir_n = key_dir;
            if (can_move(tx_q, ty_q, key_dir)) begin
              state_n = STEP;
              off_n   = '0;
              run_n   = run_held;
            end
          end
        end
        default: begin
          if (keycode == KEY_EXIT) begin
            state_n = START;
            off_n   = '0;
            run_n   = 1'b0;
          end else if (off_sum == SUM_W'(TILE_PX)) begin
            off_n  = '0;
            tx_n   = adv_x;
            ty_n   = adv_y;
            done_n = 1'b1;
            // Chain straight into the next step when a legal key is held
            if (key_hit && can_move(adv_x, adv_y, key_dir)) begin
              dir_n = key_dir;
              run_n = run_held;
            end else begin
              state_n = IDLE;
              run_n   = 1'b0;
            end
          end else begin
            off_n = off_sum[OFF_W-1:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= START;
      dir_q   <= DOWN;
      off_q   <= '0;
      tx_q    <= X_W'(START_X);
      ty_q    <= Y_W'(START_Y);
      fade_q  <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      dir_q   <= dir_n;
      off_q   <= off_n;
      tx_q    <= tx_n;
      ty_q    <= ty_n;
      fade_q  <= fade_n;
      run_q   <= run_n;
      done_q  <= done_n;
    end
  end

  assign anim_en  = frame_tick & (state_q == STEP);
  assign anim_clr = frame_tick & ((state_n == IDLE) || (state_n == START));

  anim_frame_counter #(
    .WALK_PHASE(WALK_PHASE),
    .RUN_PHASE (RUN_PHASE)
  ) u_anim (
    .Clk    (Clk),
    .Reset  (Reset),
    .en     (anim_en),
    .clr    (anim_clr),
    .run_sel(run_q),
    .frame  (anim_frame)
  );

  always_comb begin
    case (state_q)
      START:   state_num = 4'd0;
      FADE:    state_num = 4'd2;
      default: state_num = 4'd3;
    endcase
  end

  assign direction     = dir_q;
  assign charIsMoving  = (state_q == STEP);
  assign charIsRunning = run_q & charIsMoving;
  assign charMoveFrame = charIsMoving ? anim_frame : 2'd0;
  assign step_offset   = off_q;
  assign tile_x        = tx_q;
  assign tile_y        = ty_q;
  assign fade_level    = fade_q;
  assign step_done     = done_q;

endmodule

// File: doc/char_motion_fsm.md
Name: char_motion_fsm

Overview:
Parametrised successor to the top-level game/character FSM. Runs the start screen, fade-in and play states, and moves the player sprite on a tile grid. Each step runs to completion across TILE_PX pixels, at walk or run speed, and the player is clamped to the map bounds. All state advances only on frame_tick, a one-Clk-cycle pulse derived from VGA_VS, so the block lives in the system Clk domain and feeds the sprite and map renderers.

Parameters:
TILE_PX, 16, pixels per tile step; must be divisible by WALK_PX and RUN_PX
WALK_PX, 1, pixels advanced per frame when walking
RUN_PX, 2, pixels advanced per frame when running
WALK_PHASE, 10, frames per animation phase when walking
RUN_PHASE, 5, frames per animation phase when running
FADE_FRAMES, 50, fade duration in frames (≥2)
MAP_W, 32, map width in tiles
MAP_H, 32, map height in tiles
START_X, 4, reset/restart tile x
START_Y, 4, reset/restart tile y
KEY_EXIT, 8'h1B, keycode returning play to the start screen

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
keycode  in  8  current USB keycode (0 = none)
run_held  in  1  run modifier held
state_num  out  4  0 start, 2 fade, 3 play (idle or stepping)
direction  out  2  0 down, 1 up, 2 left, 3 right
charMoveFrame  out  2  sprite animation frame
charIsMoving  out  1  a step is in progress
charIsRunning  out  1  current step is at run speed
step_offset  out  $clog2(TILE_PX)  pixel offset into the current step
tile_x  out  $clog2(MAP_W)  player tile column
tile_y  out  $clog2(MAP_H)  player tile row
fade_level  out  $clog2(FADE_FRAMES)  fade progress
step_done  out  1  one-cycle pulse when a step completes

Behaviour:
- Reset: state START; direction 0; tile_x/tile_y = START_X/START_Y; all other outputs and counters 0.
- Registers change only on cycles with frame_tick=1. step_done is asserted the cycle after the completing tick and is low otherwise.
- Key decode priority: S(8'h16) > W(8'h1A) > A(8'h04) > D(8'h07). Enter = 8'h28.
- START: on Enter, go to FADE. fade_level and tile are reset to start values.
- FADE: fade_level increments once per tick. On the tick where fade_level == FADE_FRAMES-1, fade_level goes to 0 and the state goes to IDLE.
- IDLE, direction key held:
  - direction takes the key's value.
  - If the target tile is in bounds, go to STEP. Offset is 0, and the run mode (run_held) is latched for the whole step.
  - If the target tile is out of bounds (x=0 going left, x=MAP_W-1 going right, y=0 going up, y=MAP_H-1 going down), only the direction changes (turn in place).
- STEP:
  - Each tick, offset += speed, where speed is RUN_PX if running, else WALK_PX.
  - When offset+speed == TILE_PX: offset goes to 0, the tile coordinate updates, and step_done pulses.
  - On that same completing tick, if a direction key is held and its target is in bounds, a new STEP begins immediately in that direction with run_held re-latched. Otherwise the state goes to IDLE.
  - Keys pressed mid-step are ignored until completion.
- KEY_EXIT in IDLE or STEP: go to START. A step in progress is aborted: offset goes to 0 and the tile is not updated. START then restores the start tile on Enter.
- Animation:
  - A phase counter counts ticks while stepping. The phase length is RUN_PHASE or WALK_PHASE per the latched run mode.
  - Frame sequence is 0,1,2,1 and wraps.
  - The counter continues across back-to-back steps and clears to 0 on entry to IDLE or START.
  - charMoveFrame is 0 when not stepping.
- charIsMoving = (state == STEP). charIsRunning = latched run mode AND STEP.
- Reset asserted mid-step restores all reset values immediately (asynchronous).

Decomposition:
- game_pkg holds:
  - game_state_t enum: START, FADE, IDLE, STEP.
  - dir_t enum: DOWN=0, UP=1, LEFT=2, RIGHT=3.
  - Keycode constants: KEY_W, KEY_A, KEY_S, KEY_D, KEY_ENTER.
- Sub-module anim_frame_counter: phase counter plus 0,1,2,1 sequencer, with enable, clear and phase-length select inputs.

Test Plan:
- Reset, then Enter for 1 tick → state_num=2. After 50 ticks → state_num=3, fade_level=0, tile=(4,4).
- IDLE, hold S for 16 ticks, run_held=0 → step_offset runs 1..15 then 0, tile_y=5, step_done pulses once, charMoveFrame sequence 0,1.
- IDLE, hold D with run_held=1, continuously → steps every 8 ticks, tile_x=5, 6, 7, with no idle gap between steps. Animation phases change every 5 ticks.
- At tile_x=0, press A → direction=2, charIsMoving=0, tile unchanged.
- Mid-step (offset 6), KEY_EXIT → state_num=0, offset 0, tile unchanged, no step_done pulse.
- Assert Reset mid-step at offset 9 → all outputs at reset values within the same cycle.
